// File: rtl/prog_bus_mach_pkg.sv
// rtl/prog_bus_mach_pkg.sv - shared state encodings and constants for the Tiny DSP program-bus machine
package prog_bus_mach_pkg;

   localparam int MSB = 15;
   localparam int PROG_ADDR_W = 12;
   localparam logic [MSB:0] NOP = 16'h7F80;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ADDR   = 2'd1,
      STROBE = 2'd2,
      LATCH  = 2'd3
   } bus_state_t;

   // A table write always claims the bus; go_prog alone (read_prog low) is a no-op.
   function automatic logic is_request(input logic tbl_wr_req, input logic go_prog,
                                       input logic read_prog);
      return tbl_wr_req | (go_prog & read_prog);
   endfunction

endpackage

// File: rtl/prog_bus_mach_prog_counter.sv
// rtl/prog_bus_mach_prog_counter.sv - program counter with branch load and wrapping increment at phi_5
module prog_bus_mach_prog_counter #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              phi_5,
   input  logic              load_pc,
   input  logic [ADDR_W-1:0] branch_addr,
   input  logic              inc_en,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc <= '0;
      end else if (phi_5) begin
         // A taken branch wins over the fetch increment; the add wraps naturally.
         if (load_pc)
            pc <= branch_addr;
         else if (inc_en)
            pc <= pc + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/prog_bus_mach.sv
// rtl/prog_bus_mach.sv - program-bus machine (fetch, TBLR, TBLW); optional PROG_WAIT_EN adds p_ready stall
module prog_bus_mach
   import prog_bus_mach_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              phi_1,
   input  logic              phi_5,
   input  logic              go_prog,
   input  logic              read_prog,
   input  logic              tbl_sel,
   input  logic              tbl_wr_req,
   input  logic [ADDR_W-1:0] tbl_addr,
   input  logic [DATA_W-1:0] tbl_wdata,
   input  logic              load_pc,
   input  logic [ADDR_W-1:0] branch_addr,
   input  logic [DATA_W-1:0] p_rdata,
`ifdef PROG_WAIT_EN
   input  logic              p_ready,
`endif
   output logic [ADDR_W-1:0] p_address,
   output logic              p_read,
   output logic              p_write,
   output logic [DATA_W-1:0] p_wdata,
   output logic [DATA_W-1:0] p_data_out,
   output logic [ADDR_W-1:0] pc,
   output logic              prog_busy,
   output logic              prog_err
);

   bus_state_t state, state_next;
   logic       accept;
   logic       is_wr;
   logic       fetch_pend;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (phi_1 && is_request(tbl_wr_req, go_prog, read_prog)) begin
               accept     = 1'b1;
               state_next = ADDR;
            end
         end
         ADDR:   state_next = STROBE;
         STROBE: begin
`ifdef PROG_WAIT_EN
            if (p_ready)
               state_next = LATCH;
`else
            state_next = LATCH;
`endif
         end
         LATCH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Strobes decode straight from the state register so reset kills them immediately.
   assign p_read    = (state == STROBE) && !is_wr;
   assign p_write   = (state == STROBE) &&  is_wr;
   assign prog_busy = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p_address  <= '0;
         p_wdata    <= '0;
         p_data_out <= DATA_W'(NOP);
         is_wr      <= 1'b0;
         fetch_pend <= 1'b0;
         prog_err   <= 1'b0;
      end else begin
         if (accept) begin
            p_address  <= (tbl_sel || tbl_wr_req) ? tbl_addr : pc;
            p_wdata    <= tbl_wdata;
            is_wr      <= tbl_wr_req;
            fetch_pend <= !tbl_wr_req && !tbl_sel;
         end else if (phi_5) begin
            // The increment is consumed once per fetch, even when a branch overrides it.
            fetch_pend <= 1'b0;
         end
         if (state == LATCH && !is_wr)
            p_data_out <= p_rdata;
         if (phi_1 && (tbl_wr_req || go_prog) && state != IDLE)
            prog_err <= 1'b1;
      end
   end

   prog_bus_mach_prog_counter #(
      .ADDR_W (ADDR_W)
   ) u_prog_counter (
      .clk         (clk),
      .reset       (reset),
      .phi_5       (phi_5),
      .load_pc     (load_pc),
      .branch_addr (branch_addr),
      .inc_en      (fetch_pend),
      .pc          (pc)
   );

endmodule

// File: doc/prog_bus_mach.md
Name: prog_bus_mach

Overview:
Program-bus machine for the Tiny DSP. It sits directly upstream of decode_i and serves its go_prog/read_prog requests. It owns the program counter, drives the program-memory address and strobes, and registers fetched words onto p_data_out, which decode_i samples at phi_6. It also services table reads (TBLR) and table writes (TBLW) through the same bus.

Parameters:
ADDR_W, 12, program address width; the PC wraps modulo 2^ADDR_W
DATA_W, 16, program word width; equals `MSB+1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low system reset
phi_1  in  1  cycle phase 1; exactly one phi_k is high per clk, in sequence
phi_5  in  1  cycle phase 5
go_prog  in  1  program bus go flag from decode_i
read_prog  in  1  program bus read flag from decode_i
tbl_sel  in  1  execute: use tbl_addr instead of pc for this access (TBLR/TBLW)
tbl_wr_req  in  1  execute: table write request, sampled at phi_1
tbl_addr  in  ADDR_W  table address (accumulator low bits)
tbl_wdata  in  DATA_W  table write data
load_pc  in  1  execute: branch taken, sampled at phi_5
branch_addr  in  ADDR_W  branch target
p_rdata  in  DATA_W  program memory read data
p_ready  in  1  memory ready; used only when PROG_WAIT_EN is defined
p_address  out  ADDR_W  program memory address
p_read  out  1  memory read strobe
p_write  out  1  memory write strobe
p_wdata  out  DATA_W  memory write data
p_data_out  out  DATA_W  registered program data to decode_i
pc  out  ADDR_W  program counter
prog_busy  out  1  state != IDLE
prog_err  out  1  sticky: request arrived at phi_1 while the machine was not IDLE

Behaviour:
- Reset (reset low, async) clears outputs: p_address=0, p_read=0, p_write=0, p_wdata=0, pc=0, p_data_out=`NOP, prog_busy=0, prog_err=0, state=IDLE.
- States: IDLE -> ADDR -> STROBE -> LATCH -> IDLE.
- IDLE: at phi_1, evaluate requests in priority order:
  - tbl_wr_req=1: write access. go_prog is ignored this cycle.
  - go_prog=1 and read_prog=1: read access.
  - go_prog=1 and read_prog=0: no access; state stays IDLE.
- Latched at phi_1 for an accepted request: the address (tbl_addr if tbl_sel or tbl_wr_req is high, else pc), the direction, p_wdata=tbl_wdata, and a fetch flag (read with tbl_sel=0).
- ADDR (1 clk): p_address is driven; no strobes.
- STROBE (1 clk): p_read=1 for reads, or p_write=1 for writes.
- LATCH (1 clk): strobes are low; p_data_out<=p_rdata for reads only. Then return to IDLE.
- Read latency: request sampled at phi_1; p_data_out is valid from the clk edge ending phi_4 and stable through phi_6.
- p_data_out holds its last read value across writes and idle cycles.
- PC update at phi_5:
  - load_pc=1: pc<=branch_addr. This overrides the increment.
  - else, if the fetch flag is set: pc<=pc+1, wrapping 2^ADDR_W-1 -> 0.
  - Table accesses never advance the pc.
- prog_err: set if tbl_wr_req or go_prog is high at phi_1 while state != IDLE. The request is dropped and the machine continues the current access. Cleared only by reset.
- Reset asserted mid-access: strobes drop immediately; no partial data is latched.
- p_address holds its value after an access completes; the memory must ignore it when no strobe is asserted.

Optional Feature:
PROG_WAIT_EN
- Defined: STROBE holds, with its strobe asserted, until p_ready=1 is sampled. prog_busy stays high throughout. Phases continue counting, so a stall past phi_6 triggers prog_err on the next phi_1 request.
- Undefined: the p_ready port is absent and STROBE always lasts exactly 1 clk.

Decomposition:
- Shared header tdsp.h holds `MSB, `NOP, the program address width define and the state encodings (IDLE, ADDR, STROBE, LATCH as 2-bit constants).
- Natural sub-module: prog_counter. It owns pc, load, increment and wrap, with inputs phi_5, load_pc, branch_addr and inc_en.

Test Plan:
- Reset release, pc=0, memory[0]=16'h7F80, go_prog=read_prog=1 at phi_1 -> p_address=0, p_read for 1 clk at phi_3, p_data_out=16'h7F80 by phi_5, pc=1 after phi_5.
- pc=12'hFFF, fetch -> pc wraps to 0; a following fetch reads address 0.
- tbl_sel=1, tbl_addr=12'h123, read -> p_address=12'h123, data latched, pc unchanged.
- tbl_wr_req=1 and go_prog=1 together, tbl_wdata=16'hBEEF, tbl_addr=12'h040 -> one p_write pulse with p_wdata=BEEF at 12'h040; no read; p_data_out unchanged.
- Fetch at pc=5 with load_pc=1, branch_addr=12'h200 at phi_5 -> pc=12'h200, not 6.
- reset asserted during STROBE -> p_read drops asynchronously, p_data_out=`NOP, state=IDLE. With PROG_WAIT_EN defined, p_ready held low for 3 clk -> p_read stays high for 4 clk and prog_busy stays high.
